// File: rtl/mac_accum_nbits.sv
// Streaming signed multiply-accumulate feeding ReLU_Nbits.
// Accepts K pairs of N-bit signed operands over valid/ready and emits one
// 2N-bit signed dot product per K accepted beats, held until Out_ready.
// Build option: define MAC_ACC_SATURATE_EN to clamp the result to the 2N-bit
// signed range; otherwise the result wraps (low 2N bits of the sum).
module mac_accum_nbits #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     In_A,
  input  logic [N-1:0]     In_B,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [2*N-1:0]   Out,
  output logic             Out_valid,
  input  logic             Out_ready
);

  // Accumulator is wide enough that K full-range products never wrap.
  localparam int AW = 2*N + $clog2(K) + 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K-1);

`ifdef MAC_ACC_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2**(2*N-1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2**(2*N-1)));
`endif

  typedef enum logic {ACC, HOLD} state_t;

  state_t                 state;
  logic signed [AW-1:0]   acc;
  logic [CW-1:0]          cnt;

  logic signed [2*N-1:0]  a_ext;
  logic signed [2*N-1:0]  b_ext;
  logic signed [2*N-1:0]  prod;
  logic signed [AW-1:0]   sum;

  // Reduce the wide running sum to the 2N-bit output format.
  function automatic logic [2*N-1:0] fmt(input logic signed [AW-1:0] s);
`ifdef MAC_ACC_SATURATE_EN
    if (s > SAT_MAX)
      return SAT_MAX[2*N-1:0];
    else if (s < SAT_MIN)
      return SAT_MIN[2*N-1:0];
    else
      return s[2*N-1:0];
`else
    return s[2*N-1:0];
`endif
  endfunction

  // Operands are sign-extended to 2N bits so the product is computed exactly.
  assign a_ext = {{N{In_A[N-1]}}, In_A};
  assign b_ext = {{N{In_B[N-1]}}, In_B};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + {{(AW-2*N){prod[2*N-1]}}, prod};

  // Ready depends on state alone, so there is no path from Out_ready.
  assign In_ready = (state == ACC);

  // Accumulate K accepted beats, then hold the result until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      Out       <= '0;
      Out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (In_valid) begin
            if (cnt == LAST) begin
              Out       <= fmt(sum);
              Out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= sum;
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (Out_ready) begin
            Out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_nbits.sv
// Scoreboard bench for mac_accum_nbits: directed cases plus randomized traffic
// with gaps and backpressure, checked against a plain integer dot-product model.
module tb_mac_accum_nbits;

  localparam int N = 4;
  localparam int K = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   In_A = '0;
  logic [N-1:0]   In_B = '0;
  logic           In_valid = 1'b0;
  logic           In_ready;
  logic [2*N-1:0] Out;
  logic           Out_valid;
  logic           Out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int msum = 0;
  int mcnt = 0;
  logic [2*N-1:0] q[$];

  // backpressure control
  bit rand_or = 1'b0;
  bit fixed_or = 1'b1;

  mac_accum_nbits #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .In_A(In_A), .In_B(In_B), .In_valid(In_valid),
    .In_ready(In_ready), .Out(Out), .Out_valid(Out_valid), .Out_ready(Out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected output format derived from the arithmetic sum.
  function automatic logic [2*N-1:0] model_fmt(input int s);
    int hi;
    int lo;
    hi = (1 << (2*N-1)) - 1;
    lo = -(1 << (2*N-1));
`ifdef MAC_ACC_SATURATE_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    return s[2*N-1:0];
  endfunction

  // Drive one beat, retrying until the DUT accepts it.
  task automatic send(input int a, input int b);
    logic [N-1:0] av;
    logic [N-1:0] bv;
    int ia;
    int ib;
    bit done;
    av = a[N-1:0];
    bv = b[N-1:0];
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      In_A = av;
      In_B = bv;
      In_valid = 1'b1;
      if (In_ready) begin
        ia = $signed(av);
        ib = $signed(bv);
        msum += ia * ib;
        mcnt++;
        if (mcnt == K) begin
          q.push_back(model_fmt(msum));
          msum = 0;
          mcnt = 0;
        end
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 In_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      In_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    In_valid = 1'b0;
    msum = 0;
    mcnt = 0;
    q.delete();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out", Out, 0);
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_in_ready", In_ready, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Out_ready driver
  always begin
    @(negedge clk);
    Out_ready = rand_or ? ($urandom_range(0, 9) < 6) : fixed_or;
  end

  // Monitor: compares every valid output cycle against the scoreboard head.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      chk("in_ready_vs_hold", In_ready, !Out_valid);
      if (Out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", Out_valid, 0);
        end else begin
          chk("out_value", Out, q[0]);
          if (Out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    // 1. reset
    do_reset(2);

    // 2. normal dot product, back-to-back, with latency check
    send(1, 2); send(3, 4); send(-1, 5);
    chk("pre_result_valid", Out_valid, 0);
    send(0, 7);
    chk("latency_out_valid", Out_valid, 1);
    chk("latency_out", Out, 8'h09);
    drain();

    // 3. positive overflow, 4. negative overflow
    repeat (4) send(7, 7);
    drain();
    repeat (4) send(-8, 7);
    drain();

    // 5. gaps and backpressure
    fixed_or = 1'b0;
    send(1, 2); idle(3); send(3, 4); idle(3); send(-1, 5); idle(3); send(0, 7);
    repeat (5) @(negedge clk);
    #2;
    chk("bp_held_valid", Out_valid, 1);
    chk("bp_held_out", Out, 8'h09);
    fixed_or = 1'b1;
    drain();
    idle(1);
    #2;
    chk("bp_released", Out_valid, 0);

    // 6. reset mid-accumulation, then clean result
    send(7, 7); send(7, 7);
    do_reset(1);
    send(1, 2); send(3, 4); send(-1, 5); send(0, 7);
    drain();

    // reset during HOLD discards the pending result
    fixed_or = 1'b0;
    repeat (4) send(5, -3);
    do_reset(1);
    fixed_or = 1'b1;
    idle(2);
    #2;
    chk("hold_reset_no_valid", Out_valid, 0);

    // randomized traffic
    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
    end
    rand_or = 1'b0;
    fixed_or = 1'b1;
    drain();
    chk("model_partial_clear", mcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
